// File: rtl/mouse_ctl_setter.sv
// Programs cursor bounds and initial position into the mouse controller after
// reset, then writes clamped X/Y targets on move requests (one-deep pending slot).
module mouse_ctl_setter #(
    parameter int XMAX       = 799,
    parameter int YMAX       = 599,
    parameter int XINIT      = 400,
    parameter int YINIT      = 300,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_req,
    input  logic [11:0] target_x,
    input  logic [11:0] target_y,
    output logic [11:0] value,
    output logic        setmax_x,
    output logic        setmax_y,
    output logic        setx,
    output logic        sety,
    output logic        busy,
    output logic        done
);
    localparam int CW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [11:0] XMAX_V  = 12'(XMAX);
    localparam logic [11:0] YMAX_V  = 12'(YMAX);
    localparam logic [11:0] XINIT_V = 12'(XINIT);
    localparam logic [11:0] YINIT_V = 12'(YINIT);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {BOOT, MAXX, MAXY, SETX, SETY, GAP, DONE, IDLE} state_t;

    state_t        state, state_n, last, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [11:0]   cur_x, cur_y, cur_x_n, cur_y_n;
    logic          pend_v, pend_v_n;
    logic [11:0]   pend_x, pend_y, pend_x_n, pend_y_n;
    logic [11:0]   value_n;
    logic [11:0]   req_x, req_y;
    logic          in_seq;

    // Clamp happens at capture so pending and current operands are always legal.
    assign req_x  = (target_x > XMAX_V) ? XMAX_V : target_x;
    assign req_y  = (target_y > YMAX_V) ? YMAX_V : target_y;
    assign in_seq = (state == MAXX) || (state == MAXY) || (state == SETX) ||
                    (state == SETY) || (state == GAP);

    always_comb begin
        state_n  = state;
        last_n   = last;
        cnt_n    = cnt;
        cur_x_n  = cur_x;
        cur_y_n  = cur_y;
        pend_v_n = pend_v;
        pend_x_n = pend_x;
        pend_y_n = pend_y;

        if (in_seq && move_req) begin
            pend_v_n = 1'b1;
            pend_x_n = req_x;
            pend_y_n = req_y;
        end

        case (state)
            BOOT: begin
                state_n = MAXX;
                cur_x_n = XINIT_V;
                cur_y_n = YINIT_V;
            end
            MAXX, MAXY, SETX, SETY: begin
                last_n  = state;
                cnt_n   = GAP_LAST;
                state_n = GAP;
            end
            GAP: begin
                if (cnt == '0) begin
                    case (last)
                        MAXX:    state_n = MAXY;
                        MAXY:    state_n = SETX;
                        SETX:    state_n = SETY;
                        default: state_n = DONE;
                    endcase
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                if (pend_v) begin
                    // Pending wins; a request arriving now becomes the next pending.
                    state_n  = SETX;
                    cur_x_n  = pend_x;
                    cur_y_n  = pend_y;
                    pend_v_n = move_req;
                    if (move_req) begin
                        pend_x_n = req_x;
                        pend_y_n = req_y;
                    end
                end else if (move_req) begin
                    state_n = SETX;
                    cur_x_n = req_x;
                    cur_y_n = req_y;
                end else begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (move_req) begin
                    state_n = SETX;
                    cur_x_n = req_x;
                    cur_y_n = req_y;
                end
            end
            default: state_n = BOOT;
        endcase

        case (state_n)
            MAXX:    value_n = XMAX_V;
            MAXY:    value_n = YMAX_V;
            SETX:    value_n = cur_x_n;
            SETY:    value_n = cur_y_n;
            GAP:     value_n = value;
            default: value_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            last     <= MAXX;
            cnt      <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            pend_v   <= 1'b0;
            pend_x   <= '0;
            pend_y   <= '0;
            value    <= '0;
            setmax_x <= 1'b0;
            setmax_y <= 1'b0;
            setx     <= 1'b0;
            sety     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            cnt      <= cnt_n;
            cur_x    <= cur_x_n;
            cur_y    <= cur_y_n;
            pend_v   <= pend_v_n;
            pend_x   <= pend_x_n;
            pend_y   <= pend_y_n;
            value    <= value_n;
            setmax_x <= (state_n == MAXX);
            setmax_y <= (state_n == MAXY);
            setx     <= (state_n == SETX);
            sety     <= (state_n == SETY);
            busy     <= (state_n == MAXX) || (state_n == MAXY) || (state_n == SETX) ||
                        (state_n == SETY) || (state_n == GAP);
            done     <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_mouse_ctl_setter.sv
// Directed plus random bench for mouse_ctl_setter against a timeline model of
// write sequences (start cycle + operand list).
module tb_mouse_ctl_setter;
    localparam int XMAX = 799, YMAX = 599, XINIT = 400, YINIT = 300, G = 4;
    localparam int P = G + 1;

    logic        clk = 1'b0, rst = 1'b1, move_req = 1'b0;
    logic [11:0] target_x = '0, target_y = '0;
    logic [11:0] value;
    logic        setmax_x, setmax_y, setx, sety, busy, done;

    int errs = 0, nchk = 0;

    // model: active sequence, pending slot, cycle index
    int          tcur, seq_s, seq_n;
    int          kinds [4];
    int          ops   [4];
    bit          pend_v;
    int          pend_x, pend_y;

    mouse_ctl_setter #(.XMAX(XMAX), .YMAX(YMAX), .XINIT(XINIT), .YINIT(YINIT), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .move_req(move_req), .target_x(target_x), .target_y(target_y),
        .value(value), .setmax_x(setmax_x), .setmax_y(setmax_y), .setx(setx), .sety(sety),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s t=%0d got=%0d exp=%0d", tag, tcur, obs, exp);
        end
    endtask

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic start_move(input int s, input int x, input int y);
        seq_s = s; seq_n = 2;
        kinds[0] = 2; kinds[1] = 3;
        ops[0] = x; ops[1] = y;
    endtask

    task automatic model_reset();
        tcur = 0; seq_s = 0; seq_n = 4; pend_v = 0;
        for (int i = 0; i < 4; i++) kinds[i] = i;
        ops[0] = XMAX; ops[1] = YMAX; ops[2] = XINIT; ops[3] = YINIT;
    endtask

    task automatic check_now();
        int off, k, e_val;
        bit e_str [4];
        bit e_busy, e_done;
        off = tcur - seq_s;
        e_val = 0; e_busy = 0; e_done = 0;
        for (int i = 0; i < 4; i++) e_str[i] = 0;
        if (off < seq_n * P) begin
            k = off / P;
            e_val = ops[k];
            e_busy = 1;
            if (off % P == 0) e_str[kinds[k]] = 1;
        end else if (off == seq_n * P) begin
            e_done = 1;
        end
        chk("value", int'(value), e_val);
        chk("setmax_x", int'(setmax_x), int'(e_str[0]));
        chk("setmax_y", int'(setmax_y), int'(e_str[1]));
        chk("setx", int'(setx), int'(e_str[2]));
        chk("sety", int'(sety), int'(e_str[3]));
        chk("busy", int'(busy), int'(e_busy));
        chk("done", int'(done), int'(e_done));
        chk("onehot", int'($countones({setmax_x, setmax_y, setx, sety}) <= 1), 1);
    endtask

    // One cycle: check outputs, apply inputs, advance the model, step the clock.
    task automatic cyc(input logic m, input int x, input int y);
        int done_t, cx, cy;
        check_now();
        move_req = m; target_x = 12'(x); target_y = 12'(y);
        cx = clampv(x, XMAX); cy = clampv(y, YMAX);
        done_t = seq_s + seq_n * P;
        if (tcur < done_t) begin
            if (m) begin pend_v = 1; pend_x = cx; pend_y = cy; end
        end else if (tcur == done_t && pend_v) begin
            start_move(tcur + 1, pend_x, pend_y);
            pend_v = m;
            if (m) begin pend_x = cx; pend_y = cy; end
        end else if (m) begin
            start_move(tcur + 1, cx, cy);
        end
        @(posedge clk); #1;
        tcur++;
        move_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; move_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_value", int'(value), 0);
        chk("rst_strobes", int'({setmax_x, setmax_y, setx, sety}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    initial begin
        model_reset();
        // Test 1: reset defaults and init timing
        do_reset(3);
        chk("init_c0_value", int'(value), 799);
        chk("init_c0_setmax_x", int'(setmax_x), 1);
        idle(25);
        // Test 2: plain move from idle
        cyc(1'b1, 200, 150);
        chk("mv_setx_value", int'(value), 200);
        idle(12);
        // Test 3: clamped move
        cyc(1'b1, 1000, 4095);
        chk("clamp_setx_value", int'(value), 799);
        idle(12);
        // Test 4: two requests during init, last one wins
        do_reset(2);
        idle(3);
        cyc(1'b1, 10, 20);
        idle(8);
        cyc(1'b1, 30, 40);
        idle(8);
        chk("pend_setx_c21", int'(value), 30);
        idle(15);
        // Test 5: reset mid-init
        do_reset(2);
        idle(7);
        do_reset(1);
        idle(25);
        // Test 6: move in init done cycle
        do_reset(2);
        idle(20);
        cyc(1'b1, 5, 6);
        idle(15);
        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
            else cyc(($urandom_range(0, 6) == 0), int'($urandom_range(0, 4095)),
                     int'($urandom_range(0, 4095)));
        end
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
